instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 129 ++++++++++++
 tb/tb_instr_fetch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Sequential instruction fetch unit. It walks a PC through a synchronous RAM:
// one cycle issuing the read (FETCH), one cycle waiting for the data (WAIT),
// then holds the fetched word for the decoder until it is accepted (HOLD).
// A redirect (branch/jump) reloads the PC from any state and restarts the
// fetch. Any read that is still in flight is dropped.
//
// Parameters
//   WIDTH       instruction / address width (default 16)
//   RESET_PC    PC value loaded while reset is asserted
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   mem_addr     out  RAM read address (always the current PC)
//   mem_en       out  RAM read strobe, high in FETCH only
//   mem_rdata    in   RAM read data, valid the cycle after mem_en
//   instr        out  held instruction word
//   instr_valid  out  instr holds a fetched, unconsumed word (HOLD)
//   instr_ready  in   decoder accepts instr this cycle (used in HOLD only)
//   redirect_en  in   load PC from redirect_pc and restart the fetch
//   redirect_pc  in   redirect target
//   pc           out  address of the instruction being fetched or held
//   fetch_count  out  number of accepted instructions (wraps)
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_en,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [WIDTH-1:0] instr,
   output logic             instr_valid,
   input  logic             instr_ready,
   input  logic             redirect_en,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] fetch_count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_WAIT  = 2'b01,
      ST_HOLD  = 2'b10
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_instr;
   logic [WIDTH-1:0] r_count;

   state_t           w_state_next;
   logic [WIDTH-1:0] w_pc_next;
   logic [WIDTH-1:0] w_instr_next;
   logic [WIDTH-1:0] w_count_next;
   logic             w_accept;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_FETCH;
         r_pc    <= RESET_PC;
         r_instr <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_instr <= w_instr_next;
         r_count <= w_count_next;
      end
   end

   // Next-state and output decode
   always_comb begin
      w_state_next = ST_FETCH;
      w_pc_next    = r_pc;
      w_instr_next = r_instr;
      w_count_next = r_count;
      w_accept     = (r_state == ST_HOLD) && instr_ready;

      // Outputs depend on state, pc and reset only. The reset term keeps the
      // read strobe low while the state register is forced to FETCH.
      mem_en      = (r_state == ST_FETCH) && reset;
      mem_addr    = r_pc;
      instr_valid = (r_state == ST_HOLD);

      case (r_state)
         ST_FETCH: w_state_next = ST_WAIT;
         ST_WAIT: begin
            w_state_next = ST_HOLD;
            w_instr_next = mem_rdata;
         end
         ST_HOLD: begin
            if (instr_ready) begin
               w_state_next = ST_FETCH;
               w_pc_next    = r_pc + ONE;
            end else begin
               w_state_next = ST_HOLD;
            end
         end
         default: w_state_next = ST_FETCH;
      endcase

      // The held word counts as consumed even when a redirect lands on the
      // same cycle, so the count is applied before the redirect override.
      if (w_accept) begin
         w_count_next = r_count + ONE;
      end

      // A redirect overrides the PC and restarts the fetch. The in-flight
      // read (if any) is dropped, so instr keeps its old value.
      if (redirect_en) begin
         w_state_next = ST_FETCH;
         w_pc_next    = redirect_pc;
         w_instr_next = r_instr;
      end
   end

   assign instr       = r_instr;
   assign pc          = r_pc;
   assign fetch_count = r_count;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] mem_addr, mem_rdata, instr, redirect_pc, pc, fetch_count;
   logic        mem_en, instr_valid, instr_ready, redirect_en;

   // second instance for the PC wrap case
   logic [15:0] mem_addr2, mem_rdata2, instr2, pc2, fetch_count2;
   logic        mem_en2, instr_valid2;
   logic        ready2 = 1'b1;
   logic        redir2 = 1'b0;
   logic [15:0] rpc2 = 16'h0000;

   logic [15:0] ram [0:255];

   int n_chk = 0;
   int n_err = 0;

   // reference model: transaction-level view (age = cycles since fetch start)
   logic [15:0] m_pc, m_count, m_instr;
   int          m_age;

   always #5 clk = ~clk;

   instr_fetch #(.WIDTH(16), .RESET_PC(16'h0000)) u_dut (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_en(mem_en),
      .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .redirect_en(redirect_en),
      .redirect_pc(redirect_pc), .pc(pc), .fetch_count(fetch_count)
   );

   instr_fetch #(.WIDTH(16), .RESET_PC(16'hFFFF)) u_dut_wrap (
      .clk(clk), .reset(reset), .mem_addr(mem_addr2), .mem_en(mem_en2),
      .mem_rdata(mem_rdata2), .instr(instr2), .instr_valid(instr_valid2),
      .instr_ready(ready2), .redirect_en(redir2),
      .redirect_pc(rpc2), .pc(pc2), .fetch_count(fetch_count2)
   );

   // Synchronous RAM: data valid the cycle after the strobe; garbage otherwise
   always @(posedge clk) begin
      mem_rdata  <= mem_en  ? ram[mem_addr[7:0]]  : 16'($urandom);
      mem_rdata2 <= mem_en2 ? ram[mem_addr2[7:0]] : 16'($urandom);
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_count = 16'h0000; m_instr = 16'h0000; m_age = 0;
   endtask

   task automatic model_edge(input logic rdy, input logic rdr, input logic [15:0] rpc);
      logic acc;
      acc = (m_age >= 2) && rdy;
      if (acc) m_count = m_count + 16'd1;
      if (rdr) begin
         m_pc = rpc; m_age = 0;
      end else if (acc) begin
         m_pc = m_pc + 16'd1; m_age = 0;
      end else if (m_age < 2) begin
         m_age = m_age + 1;
         if (m_age == 2) m_instr = ram[m_pc[7:0]];
      end
   endtask

   task automatic step(input logic rdy, input logic rdr, input logic [15:0] rpc);
      instr_ready = rdy; redirect_en = rdr; redirect_pc = rpc;
      @(posedge clk);
      model_edge(rdy, rdr, rpc);
      #1;
      $display("cyc rdy=%0b rdr=%0b rpc=%h -> pc=%h en=%0b v=%0b instr=%h cnt=%h",
               rdy, rdr, rpc, pc, mem_en, instr_valid, instr, fetch_count);
   endtask

   task automatic chk_model();
      chk("pc", pc, m_pc);
      chk("mem_addr", mem_addr, m_pc);
      chk("mem_en", {15'd0, mem_en}, {15'd0, (m_age == 0) && reset});
      chk("instr_valid", {15'd0, instr_valid}, {15'd0, m_age >= 2});
      chk("instr", instr, m_instr);
      chk("fetch_count", fetch_count, m_count);
   endtask

   typedef struct {
      logic        rdy;
      logic        rdr;
      logic [15:0] rpc;
      logic [15:0] e_pc;
      logic        e_en;
      logic        e_v;
      logic [15:0] e_instr;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl [21];

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'd0};
      tbl[1]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0512, 16'd0};
      tbl[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0512, 16'd1};
      tbl[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0512, 16'd1};
      tbl[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h1111, 16'd1};
      for (int k = 5; k <= 9; k++)
         tbl[k] = '{1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h1111, 16'd1};
      tbl[10] = '{1'b1, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b0, 16'h1111, 16'd2};
      tbl[11] = '{1'b1, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b0, 16'h1111, 16'd2};
      tbl[12] = '{1'b1, 1'b1, 16'h0040, 16'h0040, 1'b1, 1'b0, 16'h1111, 16'd2};
      tbl[13] = '{1'b1, 1'b0, 16'h0000, 16'h0040, 1'b0, 1'b0, 16'h1111, 16'd2};
      tbl[14] = '{1'b0, 1'b0, 16'h0000, 16'h0040, 1'b0, 1'b1, 16'h4040, 16'd2};
      tbl[15] = '{1'b0, 1'b1, 16'h0003, 16'h0003, 1'b1, 1'b0, 16'h4040, 16'd2};
      tbl[16] = '{1'b1, 1'b0, 16'h0000, 16'h0003, 1'b0, 1'b0, 16'h4040, 16'd2};
      tbl[17] = '{1'b0, 1'b0, 16'h0000, 16'h0003, 1'b0, 1'b1, 16'h3333, 16'd2};
      tbl[18] = '{1'b1, 1'b1, 16'h0010, 16'h0010, 1'b1, 1'b0, 16'h3333, 16'd3};
      tbl[19] = '{1'b0, 1'b0, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'h3333, 16'd3};
      tbl[20] = '{1'b0, 1'b0, 16'h0000, 16'h0010, 1'b0, 1'b1, 16'h1010, 16'd3};

      for (int k = 0; k < 256; k++) ram[k] = 16'($urandom);
      ram[8'h00] = 16'h0512; ram[8'h01] = 16'h1111; ram[8'h02] = 16'h2222;
      ram[8'h03] = 16'h3333; ram[8'h10] = 16'h1010; ram[8'h40] = 16'h4040;
      ram[8'h41] = 16'h4141;

      instr_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0000;
      model_reset();

      // held in reset across a few edges
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pc", pc, 16'h0000);
      chk("rst_mem_en", {15'd0, mem_en}, 16'd0);
      chk("rst_valid", {15'd0, instr_valid}, 16'd0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_count", fetch_count, 16'h0000);
      chk("rst_wrap_pc", pc2, 16'hFFFF);

      // release: first cycle is FETCH at RESET_PC
      reset = 1'b1;
      #1;
      chk("c1_mem_en", {15'd0, mem_en}, 16'd1);
      chk("c1_mem_addr", mem_addr, 16'h0000);
      chk("c1_valid", {15'd0, instr_valid}, 16'd0);
      chk("c1_wrap_addr", mem_addr2, 16'hFFFF);

      // directed table
      for (int i = 0; i < 21; i++) begin
         step(tbl[i].rdy, tbl[i].rdr, tbl[i].rpc);
         chk($sformatf("t%0d_pc", i), pc, tbl[i].e_pc);
         chk($sformatf("t%0d_addr", i), mem_addr, tbl[i].e_pc);
         chk($sformatf("t%0d_en", i), {15'd0, mem_en}, {15'd0, tbl[i].e_en});
         chk($sformatf("t%0d_valid", i), {15'd0, instr_valid}, {15'd0, tbl[i].e_v});
         chk($sformatf("t%0d_instr", i), instr, tbl[i].e_instr);
         chk($sformatf("t%0d_cnt", i), fetch_count, tbl[i].e_cnt);
         if (i == 2) begin
            // RESET_PC=FFFF instance, three cycles in: one accept done
            chk("wrap_pc", pc2, 16'h0000);
            chk("wrap_mem_en", {15'd0, mem_en2}, 16'd1);
            chk("wrap_mem_addr", mem_addr2, 16'h0000);
            chk("wrap_count", fetch_count2, 16'd1);
         end
      end

      // reset pulsed while in HOLD: effect without a clock edge
      chk("pre_rst_valid", {15'd0, instr_valid}, 16'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_valid", {15'd0, instr_valid}, 16'd0);
      chk("async_pc", pc, 16'h0000);
      chk("async_mem_en", {15'd0, mem_en}, 16'd0);
      chk("async_instr", instr, 16'h0000);
      chk("async_count", fetch_count, 16'h0000);
      reset = 1'b1;
      model_reset();
      #1;
      chk_model();

      // randomized run against the reference model
      for (int i = 0; i < 3000; i++) begin
         logic rdy, rdr;
         logic [15:0] rpc;
         rdy = ($urandom_range(0, 2) != 0);
         rdr = ($urandom_range(0, 7) == 0);
         rpc = 16'($urandom);
         step(rdy, rdr, rpc);
         chk_model();
         if (i % 700 == 350) begin
            #1 reset = 1'b0;
            model_reset();
            #1;
            chk_model();
            reset = 1'b1;
            #1;
            chk_model();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
